// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: channel FSM encoding,
// default counter width and the named channel slots.
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } ch_state_t;

  localparam int CNT_W_DEF = 16;
  localparam int CH_IDX_W  = 2;

  localparam int CH_PIXEL = 0;
  localparam int CH_GAME  = 1;
  localparam int CH_SOUND = 2;

  // D=0 parks a running channel rather than dividing by zero.
  function automatic ch_state_t ch_state(input logic en, input logic div_zero);
    if (!en)          return ST_OFF;
    else if (div_zero) return ST_STALL;
    else              return ST_RUN;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period counter, live divisor, shadow divisor with a
// pending flag, and the registered one-cycle tick strobe.
module tick_channel
  import tick_scheduler_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             resync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shad_q, shad_d;
  logic [CNT_W-1:0] div_m1;
  logic             tick_d, pend_d;
  logic             wrap, apply;
  ch_state_t        st;

  always_comb begin
    st     = ch_state(en, div_q == '0);
    div_m1 = (st == ST_RUN) ? div_q - CNT_W'(1) : '0;
    wrap   = (st == ST_RUN) && (cnt_q == div_m1);
    // Divisor changes only land on a period boundary or while the channel is idle.
    apply  = pending && (resync || wrap || (st != ST_RUN));

    cnt_d  = cnt_q;
    tick_d = 1'b0;
    div_d  = div_q;
    shad_d = shad_q;
    pend_d = pending;

    if (resync) begin
      cnt_d = '0;
    end else begin
      unique case (st)
        ST_RUN: begin
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end

    if (apply) begin
      div_d  = shad_q;
      pend_d = 1'b0;
    end

    // The top never issues wr while pending is set, so this cannot race apply.
    if (wr) begin
      shad_d = wr_div;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_q   <= CNT_W'(DEFAULT_DIV);
      shad_q  <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      shad_q  <= shad_d;
      pending <= pend_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Runtime-programmable clock-enable scheduler: NUM_CH tick channels plus the
// divisor config port, out-of-range error pulse and busy status.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   en,
  input  logic                resync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_err,
  output logic [NUM_CH-1:0]   tick,
  output logic                busy
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic              in_range;
  logic              accept;

  // Out-of-range writes are always accepted so a bad index can never stall the port.
  always_comb begin
    cfg_ready = 1'b1;
    in_range  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_IDX_W'(i)) begin
        in_range  = 1'b1;
        cfg_ready = !pending[i];
      end
    end
    accept = cfg_valid && cfg_ready;
    wr     = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr[i] = accept && (cfg_ch == CH_IDX_W'(i));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= accept && !in_range;
  end

  assign busy = |pending;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[g]),
      .resync  (resync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule
